mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sole owner of the byte-serial RAM port. Arbitrates between three requesters with fixed priority:
//  ROB commit (stores, IO reads) > LSB loads > instruction fetch.
//  Multi-byte accesses are sequenced one byte per cycle, little-endian.
//  Each access ends with a one-cycle done pulse to the granted requester.
//  Misbranch flush aborts speculative traffic (LSB, fetch) but never a ROB commit access.
// PARAMETERS
//  IO_BASE  32'h30000  addresses >= IO_BASE are the IO region (writes gated by io_buffer_full)
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, synchronous, active-high
//  rdy             in   1   global enable; low = freeze all state and outputs
//  flush           in   1   misbranch flush (ROB out_xbp)
//  io_buffer_full  in   1   IO write buffer full
//  mem_din         in   8   RAM read byte (valid 1 cycle after mem_a)
//  mem_dout        out  8   RAM write byte
//  mem_a           out  32  RAM byte address
//  mem_wr          out  1   1 = write, 0 = read
//  rob_req         in   1   ROB access request (held until rob_done)
//  rob_we          in   1   1 = store, 0 = IO read
//  rob_size        in   3   bytes: 1, 2 or 4
//  rob_addr        in   32  start address
//  rob_wdata       in   32  store data, byte k = bits[8k+7:8k]
//  rob_done        out  1   one-cycle completion pulse
//  rob_rdata       out  32  IO-read data, zero-extended, valid with rob_done
//  lsb_req         in   1   LSB load request (held until lsb_done or flush)
//  lsb_size        in   3   bytes: 1, 2 or 4
//  lsb_addr        in   32  load address
//  lsb_done        out  1   one-cycle completion pulse
//  lsb_rdata       out  32  load data, zero-extended
//  if_req          in   1   fetch request, always 4 bytes
//  if_addr         in   32  fetch PC
//  if_done         out  1   one-cycle completion pulse
//  if_rdata        out  32  instruction word
// BEHAVIOUR
//  Reset: state=IDLE; mem_a=0, mem_dout=0, mem_wr=0; all *_done=0; all *_rdata=0; cnt=0.
//  rdy=0: no register changes; rdy=1 and rst=0: normal operation.
//  States: IDLE, READ, WRITE, RECOVER. cnt = 3-bit byte counter; n = latched size.
//  IDLE, edge E0: grant highest-priority eligible request; latch addr/size/wdata/owner; cnt <= 1.
//   - ROB eligible if rob_req && !(rob_we && rob_addr >= IO_BASE && io_buffer_full).
//     A gated ROB write lets LSB/IF be granted.
//   - LSB and IF are not eligible while flush=1.
//   - Read grant: mem_a <= addr, mem_wr <= 0, go READ.
//   - Write grant: mem_a <= addr, mem_dout <= byte0, mem_wr <= 1, go WRITE.
//   - No grant: mem_a <= 0, mem_wr <= 0.
//  READ, edge Ek (k=1..n): capture mem_din into byte k-1.
//   - If k<n: mem_a <= addr+k.
//   - If k=n: drive owner's rdata, pulse owner's done, mem_a <= 0, go RECOVER.
//  WRITE, edge Ek (k=1..n-1): mem_a <= addr+k, mem_dout <= byte k.
//   - At k=n: mem_wr <= 0, mem_a <= 0, pulse rob_done, go RECOVER.
//  Latency: done registered n edges after grant. Port busy n+1 cycles, plus 1 RECOVER cycle.
//  RECOVER: one cycle, no grant; requester drops req meanwhile. Then IDLE.
//  Address arithmetic: 32-bit, wraps modulo 2^32. rdata upper bytes beyond n are 0.
//  Flush during LSB/IF access (any state except RECOVER):
//   - abort at that edge: mem_wr <= 0, mem_a <= 0, no done, go IDLE.
//  Flush during ROB access: ignored; access completes and rob_done pulses.
//  *_done never high for more than one cycle; at most one done per cycle.
//  Size values other than 1/2/4 are illegal; bench asserts they never occur.
//  Requests changing operands while granted: undefined; bench asserts stability.
// TESTING
//  1. LSB load size 4 @0x100, RAM bytes 11 22 33 44
//     -> lsb_done 4 edges after grant, lsb_rdata=0x44332211; RECOVER 1 cycle.
//  2. ROB SH @0x200 data 0x0000BEEF
//     -> mem_wr=1 two cycles, (0x200,EF), (0x201,BE); rob_done next edge.
//  3. if_req, lsb_req, rob_req rise same cycle -> order ROB, LSB, IF; each done exactly once.
//  4. ROB SB @0x30000 with io_buffer_full=1, if_req=1
//     -> IF served first; ROB granted the cycle after io_buffer_full falls.
//  5. flush mid LSB read (cnt=2) -> no lsb_done, mem_a=0, IDLE;
//     flush mid ROB SW -> rob_done still pulses.
//  6. rdy=0 for 3 cycles mid IF read -> outputs frozen; completes with correct if_rdata.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its three requesters and the byte-serial RAM port.
// slave = arbiter view, master = requester/RAM environment view.
interface mem_arbiter_if;
   logic        rdy;
   logic        flush;
   logic        io_buffer_full;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        rob_req;
   logic        rob_we;
   logic [2:0]  rob_size;
   logic [31:0] rob_addr;
   logic [31:0] rob_wdata;
   logic        rob_done;
   logic [31:0] rob_rdata;
   logic        lsb_req;
   logic [2:0]  lsb_size;
   logic [31:0] lsb_addr;
   logic        lsb_done;
   logic [31:0] lsb_rdata;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_rdata;

   modport slave (
      input  rdy, flush, io_buffer_full, mem_din,
      input  rob_req, rob_we, rob_size, rob_addr, rob_wdata,
      input  lsb_req, lsb_size, lsb_addr,
      input  if_req, if_addr,
      output mem_dout, mem_a, mem_wr,
      output rob_done, rob_rdata, lsb_done, lsb_rdata, if_done, if_rdata
   );

   modport master (
      output rdy, flush, io_buffer_full, mem_din,
      output rob_req, rob_we, rob_size, rob_addr, rob_wdata,
      output lsb_req, lsb_size, lsb_addr,
      output if_req, if_addr,
      input  mem_dout, mem_a, mem_wr,
      input  rob_done, rob_rdata, lsb_done, lsb_rdata, if_done, if_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority owner of the byte-serial RAM port (ROB > LSB > fetch); multi-byte
// accesses run one byte per cycle little-endian, ending with a done pulse to the owner.
module mem_arbiter #(
   parameter logic [31:0] IO_BASE = 32'h30000
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, RECOVER} state_t;
   typedef enum logic [1:0] {OWN_ROB, OWN_LSB, OWN_IF} owner_t;

   state_t      state, state_nx;
   owner_t      owner, owner_nx;
   logic [2:0]  cnt, cnt_nx, n, n_nx;
   logic [31:0] addr, addr_nx, wdata, wdata_nx, rbuf, rbuf_nx;
   logic [31:0] mem_a_nx;
   logic [7:0]  mem_dout_nx;
   logic        mem_wr_nx;
   logic        rob_done_nx, lsb_done_nx, if_done_nx;
   logic [31:0] rob_rdata_nx, lsb_rdata_nx, if_rdata_nx;

   logic        rob_ok, lsb_ok, if_ok, abort, last;
   logic [1:0]  idx;
   logic [31:0] rd_word;

   always_comb begin
      state_nx     = state;
      owner_nx     = owner;
      cnt_nx       = cnt;
      n_nx         = n;
      addr_nx      = addr;
      wdata_nx     = wdata;
      rbuf_nx      = rbuf;
      mem_a_nx     = bus.mem_a;
      mem_dout_nx  = bus.mem_dout;
      mem_wr_nx    = bus.mem_wr;
      rob_done_nx  = 1'b0;
      lsb_done_nx  = 1'b0;
      if_done_nx   = 1'b0;
      rob_rdata_nx = bus.rob_rdata;
      lsb_rdata_nx = bus.lsb_rdata;
      if_rdata_nx  = bus.if_rdata;

      // An IO store blocked by a full buffer steps aside so loads/fetch keep flowing.
      rob_ok = bus.rob_req && !(bus.rob_we && bus.rob_addr >= IO_BASE && bus.io_buffer_full);
      lsb_ok = bus.lsb_req && !bus.flush;
      if_ok  = bus.if_req && !bus.flush;
      abort  = bus.flush && owner != OWN_ROB && (state == READ || state == WRITE);
      last   = (cnt == n);
      idx    = cnt[1:0] - 2'd1;
      rd_word = rbuf;
      rd_word[{idx, 3'b000} +: 8] = bus.mem_din;

      if (abort) begin
         mem_a_nx  = '0;
         mem_wr_nx = 1'b0;
         state_nx  = IDLE;
      end else begin
         case (state)
            IDLE: begin
               mem_a_nx  = '0;
               mem_wr_nx = 1'b0;
               if (rob_ok || lsb_ok || if_ok) begin
                  cnt_nx  = 3'd1;
                  rbuf_nx = '0;
                  if (rob_ok) begin
                     owner_nx = OWN_ROB;
                     addr_nx  = bus.rob_addr;
                     n_nx     = bus.rob_size;
                     wdata_nx = bus.rob_wdata;
                  end else if (lsb_ok) begin
                     owner_nx = OWN_LSB;
                     addr_nx  = bus.lsb_addr;
                     n_nx     = bus.lsb_size;
                  end else begin
                     owner_nx = OWN_IF;
                     addr_nx  = bus.if_addr;
                     n_nx     = 3'd4;
                  end
                  mem_a_nx = addr_nx;
                  if (rob_ok && bus.rob_we) begin
                     mem_dout_nx = bus.rob_wdata[7:0];
                     mem_wr_nx   = 1'b1;
                     state_nx    = WRITE;
                  end else begin
                     state_nx = READ;
                  end
               end
            end
            READ: begin
               rbuf_nx = rd_word;
               if (last) begin
                  mem_a_nx = '0;
                  state_nx = RECOVER;
                  case (owner)
                     OWN_ROB: begin rob_rdata_nx = rd_word; rob_done_nx = 1'b1; end
                     OWN_LSB: begin lsb_rdata_nx = rd_word; lsb_done_nx = 1'b1; end
                     default: begin if_rdata_nx  = rd_word; if_done_nx  = 1'b1; end
                  endcase
               end else begin
                  mem_a_nx = addr + {29'd0, cnt};
                  cnt_nx   = cnt + 3'd1;
               end
            end
            WRITE: begin
               if (last) begin
                  mem_wr_nx   = 1'b0;
                  mem_a_nx    = '0;
                  rob_done_nx = 1'b1;
                  state_nx    = RECOVER;
               end else begin
                  mem_a_nx    = addr + {29'd0, cnt};
                  mem_dout_nx = wdata[{cnt[1:0], 3'b000} +: 8];
                  cnt_nx      = cnt + 3'd1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         owner         <= OWN_ROB;
         cnt           <= '0;
         n             <= '0;
         addr          <= '0;
         wdata         <= '0;
         rbuf          <= '0;
         bus.mem_a     <= '0;
         bus.mem_dout  <= '0;
         bus.mem_wr    <= 1'b0;
         bus.rob_done  <= 1'b0;
         bus.lsb_done  <= 1'b0;
         bus.if_done   <= 1'b0;
         bus.rob_rdata <= '0;
         bus.lsb_rdata <= '0;
         bus.if_rdata  <= '0;
      end else if (bus.rdy) begin
         state         <= state_nx;
         owner         <= owner_nx;
         cnt           <= cnt_nx;
         n             <= n_nx;
         addr          <= addr_nx;
         wdata         <= wdata_nx;
         rbuf          <= rbuf_nx;
         bus.mem_a     <= mem_a_nx;
         bus.mem_dout  <= mem_dout_nx;
         bus.mem_wr    <= mem_wr_nx;
         bus.rob_done  <= rob_done_nx;
         bus.lsb_done  <= lsb_done_nx;
         bus.if_done   <= if_done_nx;
         bus.rob_rdata <= rob_rdata_nx;
         bus.lsb_rdata <= lsb_rdata_nx;
         bus.if_rdata  <= if_rdata_nx;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter; RAM reads come from an address-hash ROM,
// writes are logged, and a timing/priority model predicts every done cycle and data word.
module tb_mem_arbiter;
   localparam logic [31:0] IO_BASE = 32'h30000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if bus();
   mem_arbiter #(.IO_BASE(IO_BASE)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Read data is a pure function of the full address, so aliasing bugs show up.
   function automatic logic [7:0] rom(input logic [31:0] a);
      logic [7:0] b;
      if (a[31:2] == 30'h40) b = 8'h11 * ({6'd0, a[1:0]} + 8'd1);
      else b = (a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
      return b;
   endfunction
   assign bus.mem_din = rom(bus.mem_a);

   function automatic logic [31:0] rd_exp(input logic [31:0] a, input logic [2:0] n);
      logic [31:0] w = '0;
      for (int i = 0; i < int'(n); i++) w[8*i +: 8] = rom(a + 32'(i));
      return w;
   endfunction

   int checks = 0, errors = 0, cyc = 0;
   int rob_dn, lsb_dn, if_dn, rob_dc, lsb_dc, if_dc;
   logic [31:0] rob_rd, lsb_rd, if_rd;
   logic [39:0] wlog[$];

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      rob_dn = 0; lsb_dn = 0; if_dn = 0;
      rob_dc = -1; lsb_dc = -1; if_dc = -1;
      wlog.delete();
   endtask

   task automatic step();
      if (bus.rdy && bus.mem_wr) wlog.push_back({bus.mem_a, bus.mem_dout});
      @(posedge clk); #1; cyc++;
      if (bus.rob_done || bus.lsb_done || bus.if_done) begin
         chk("done_onehot", 40'($countones({bus.rob_done, bus.lsb_done, bus.if_done})), 40'd1);
         chk("done_mem_a", 40'(bus.mem_a), 40'd0);
         chk("done_mem_wr", 40'(bus.mem_wr), 40'd0);
      end
      if (bus.rob_done) begin rob_dn++; rob_dc = cyc; rob_rd = bus.rob_rdata; end
      if (bus.lsb_done) begin lsb_dn++; lsb_dc = cyc; lsb_rd = bus.lsb_rdata; end
      if (bus.if_done)  begin if_dn++;  if_dc  = cyc; if_rd  = bus.if_rdata;  end
   endtask

   // One batch of simultaneous requests; the model orders grants by priority and
   // charges n edges per access plus one RECOVER edge between accesses.
   task automatic round(input bit ur, input bit rwe, input logic [2:0] rsz,
                        input logic [31:0] ra, input logic [31:0] rwd,
                        input bit iof, input int rel_x,
                        input bit ul, input logic [2:0] lsz, input logic [31:0] la,
                        input bit ui, input logic [31:0] ia,
                        input int fl_at, input int frz_at);
      int c0, nxt, rel, e_rob, e_lsb, e_if, last_o;
      bit gated, others, odone;
      logic [31:0] fa;
      clr();
      c0 = cyc;
      gated  = ur && rwe && ra >= IO_BASE && iof;
      others = ul || ui;
      nxt = c0 + 1; e_rob = -1; e_lsb = -1; e_if = -1;
      if (ur && !gated) begin e_rob = nxt + int'(rsz); nxt = e_rob + 2; end
      if (ul) begin e_lsb = nxt + int'(lsz); nxt = e_lsb + 2; end
      if (ui) begin e_if = nxt + 4; nxt = e_if + 2; end
      if (gated) begin
         rel = (others ? nxt - 2 : c0 + 3) + rel_x;
         e_rob = ((nxt > rel + 1) ? nxt : rel + 1) + int'(rsz);
      end
      if (frz_at >= 0) begin
         if (e_rob > c0 + frz_at) e_rob += 3;
         if (e_lsb > c0 + frz_at) e_lsb += 3;
         if (e_if  > c0 + frz_at) e_if  += 3;
      end

      bus.rob_req = ur; bus.rob_we = rwe; bus.rob_size = rsz; bus.rob_addr = ra;
      bus.rob_wdata = rwd; bus.io_buffer_full = iof;
      bus.lsb_req = ul; bus.lsb_size = lsz; bus.lsb_addr = la;
      bus.if_req = ui; bus.if_addr = ia;
      fa = '0;
      for (int t = 0; t < 100; t++) begin
         if ((!ur || rob_dn > 0) && (!ul || lsb_dn > 0) && (!ui || if_dn > 0)) break;
         step();
         if (bus.rob_done) bus.rob_req = 1'b0;
         if (bus.lsb_done) bus.lsb_req = 1'b0;
         if (bus.if_done)  bus.if_req  = 1'b0;
         bus.flush = (fl_at >= 0 && cyc == c0 + fl_at);
         if (gated && bus.io_buffer_full) begin
            odone  = (!ul || lsb_dn > 0) && (!ui || if_dn > 0);
            last_o = (lsb_dc > if_dc) ? lsb_dc : if_dc;
            if (others && odone && cyc >= last_o + rel_x) bus.io_buffer_full = 1'b0;
            if (!others && cyc >= c0 + 3 + rel_x) bus.io_buffer_full = 1'b0;
         end
         if (frz_at >= 0) begin
            if (cyc == c0 + frz_at) begin
               bus.rdy = 1'b0; fa = bus.mem_a;
            end else if (!bus.rdy) begin
               chk("frozen_mem_a", 40'(bus.mem_a), 40'(fa));
               if (cyc == c0 + frz_at + 3) bus.rdy = 1'b1;
            end
         end
      end
      bus.rob_req = 1'b0; bus.lsb_req = 1'b0; bus.if_req = 1'b0;
      bus.flush = 1'b0; bus.rdy = 1'b1; bus.io_buffer_full = 1'b0;
      step();

      chk("rob_count", 40'(rob_dn), 40'(ur));
      chk("lsb_count", 40'(lsb_dn), 40'(ul));
      chk("if_count",  40'(if_dn),  40'(ui));
      if (ur) chk("rob_done_cyc", 40'(rob_dc - c0), 40'(e_rob - c0));
      if (ul) chk("lsb_done_cyc", 40'(lsb_dc - c0), 40'(e_lsb - c0));
      if (ui) chk("if_done_cyc",  40'(if_dc - c0),  40'(e_if - c0));
      if (ur && !rwe) chk("rob_rdata", 40'(rob_rd), 40'(rd_exp(ra, rsz)));
      if (ul) chk("lsb_rdata", 40'(lsb_rd), 40'(rd_exp(la, lsz)));
      if (ui) chk("if_rdata",  40'(if_rd),  40'(rd_exp(ia, 3'd4)));
      if (ur && rwe) begin
         chk("wlog_len", 40'(wlog.size()), 40'(rsz));
         for (int i = 0; i < int'(rsz); i++)
            if (i < wlog.size()) chk("wlog_entry", wlog[i], {ra + 32'(i), rwd[8*i +: 8]});
      end else begin
         chk("wlog_len", 40'(wlog.size()), 40'd0);
      end
   endtask

   function automatic logic [2:0] rsize();
      case ($urandom_range(0, 2))
         0: return 3'd1;
         1: return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [31:0] raddr();
      case ($urandom_range(0, 3))
         0: return $urandom & 32'h0000_FFFF;
         1: return IO_BASE + 32'($urandom_range(0, 255));
         2: return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
         default: return $urandom;
      endcase
   endfunction

   bit r_ur, r_ul, r_ui, r_we, r_iof;

   initial begin
      bus.rdy = 1'b1; bus.flush = 1'b0; bus.io_buffer_full = 1'b0;
      bus.rob_req = 1'b0; bus.rob_we = 1'b0; bus.rob_size = 3'd1; bus.rob_addr = '0; bus.rob_wdata = '0;
      bus.lsb_req = 1'b0; bus.lsb_size = 3'd1; bus.lsb_addr = '0;
      bus.if_req = 1'b0; bus.if_addr = '0;
      clr();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_a", 40'(bus.mem_a), 40'd0);
      chk("rst_mem_wr", 40'(bus.mem_wr), 40'd0);
      chk("rst_mem_dout", 40'(bus.mem_dout), 40'd0);
      chk("rst_dones", 40'({bus.rob_done, bus.lsb_done, bus.if_done}), 40'd0);
      chk("rst_rdata", 40'(bus.rob_rdata | bus.lsb_rdata | bus.if_rdata), 40'd0);
      rst = 1'b0;

      // LSB word load from the 11 22 33 44 window
      round(0, 0, 3'd1, 0, 0, 0, 0, 1, 3'd4, 32'h100, 0, 0, -1, -1);
      chk("t1_rdata", 40'(lsb_rd), 40'h0044332211);

      // ROB halfword store
      round(1, 1, 3'd2, 32'h200, 32'h0000BEEF, 0, 0, 0, 3'd1, 0, 0, 0, -1, -1);
      if (wlog.size() >= 2) begin
         chk("t2_byte0", wlog[0], {32'h200, 8'hEF});
         chk("t2_byte1", wlog[1], {32'h201, 8'hBE});
      end

      // all three at once
      round(1, 1, 3'd4, 32'h400, 32'hCAFEF00D, 0, 0, 1, 3'd2, 32'h410, 1, 32'h420, -1, -1);

      // gated IO store yields to fetch, then goes once the buffer drains
      round(1, 1, 3'd1, IO_BASE, 32'h5A, 1, 4, 0, 3'd1, 0, 1, 32'h800, -1, -1);

      // flush aborts an LSB load at cnt=2
      clr();
      bus.lsb_req = 1'b1; bus.lsb_size = 3'd4; bus.lsb_addr = 32'h500;
      step(); chk("t5_grant_a", 40'(bus.mem_a), 40'h500);
      step(); chk("t5_cnt2_a", 40'(bus.mem_a), 40'h501);
      bus.flush = 1'b1;
      step();
      chk("t5_abort_a", 40'(bus.mem_a), 40'd0);
      chk("t5_abort_wr", 40'(bus.mem_wr), 40'd0);
      bus.flush = 1'b0; bus.lsb_req = 1'b0;
      repeat (3) step();
      chk("t5_no_lsb_done", 40'(lsb_dn), 40'd0);
      round(0, 0, 3'd1, 0, 0, 0, 0, 0, 3'd1, 0, 1, 32'h900, -1, -1);
      // flush cannot stop a ROB store
      round(1, 1, 3'd4, 32'h300, 32'h12345678, 0, 0, 0, 3'd1, 0, 0, 0, 2, -1);

      // rdy low for three cycles in the middle of a fetch
      round(0, 0, 3'd1, 0, 0, 0, 0, 0, 3'd1, 0, 1, 32'h1000, -1, 2);

      for (int r = 0; r < 30; r++) begin
         do begin
            r_ur = 1'($urandom_range(0, 1));
            r_ul = 1'($urandom_range(0, 1));
            r_ui = 1'($urandom_range(0, 1));
         end while (!(r_ur || r_ul || r_ui));
         r_we  = 1'($urandom_range(0, 1));
         r_iof = 1'($urandom_range(0, 1));
         round(r_ur, r_we, rsize(), raddr(), $urandom, r_iof, $urandom_range(0, 3),
               r_ul, rsize(), raddr(), r_ui, raddr(), -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
